cv32e40x_clic_int_controller: RTL and testbench
===============================================

Name: cv32e40x_clic_int_controller

Overview:
Parametrised successor to the fixed 32-line level-only interrupt controller. It supports NUM_IRQ lines, each with a per-line enable, a priority level and a trigger mode (level or rising edge). It latches edge-triggered events as pending and arbitrates by priority against a threshold. It presents one registered request to the controller and holds it stable until the controller acknowledges the request, withdraws it, or a higher-priority line preempts it. It sits between the external irq lines and cv32e40x_controller, and takes its configuration from cv32e40x_cs_registers.

Parameters:
- NUM_IRQ, 64, number of interrupt lines. Legal range 2..1024.
- PRIO_BITS, 3, width of each line's priority level. Legal range 1..8.
- IRQ_MASK_P, all ones (NUM_IRQ bits), lines that physically exist. A masked bit is forced to 0 in every vector.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset.
- irq_i  in  NUM_IRQ  raw interrupt lines.
- irq_en_i  in  NUM_IRQ  per-line enable (clicintie).
- irq_edge_i  in  NUM_IRQ  trigger mode per line: 1 = rising edge, 0 = level.
- irq_prio_i  in  NUM_IRQ*PRIO_BITS  flat priority vector. Line k uses bits [k*PRIO_BITS +: PRIO_BITS].
- irq_thresh_i  in  PRIO_BITS  minimum threshold (mintthresh).
- m_ie_i  in  1  global machine interrupt enable.
- irq_ack_i  in  1  controller has taken the presented interrupt.
- irq_req_ctrl_o  out  1  interrupt request.
- irq_id_ctrl_o  out  $clog2(NUM_IRQ)  id of the requested line.
- irq_prio_ctrl_o  out  PRIO_BITS  priority of the requested line.
- irq_wu_ctrl_o  out  1  unregistered wake-up.
- mip_o  out  NUM_IRQ  pending vector.

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset rst is asynchronous and active-high. All flops reset to 0 and the FSM resets to IDLE.
- Reset values of outputs: irq_req_ctrl_o=0, irq_id_ctrl_o=0, irq_prio_ctrl_o=0, mip_o=0. irq_wu_ctrl_o is combinational and equals |(irq_i & irq_en_i) even while rst is high.
- Input stage: irq_q <= irq_i & IRQ_MASK_P. irq_q2 <= irq_q.
- Edge detect: edge = irq_q & ~irq_q2.
- Edge pending register epend_q:
  - Set on edge.
  - Cleared for line irq_id_ctrl_o when irq_ack_i=1 in state REQ.
  - If set and clear hit the same line in the same cycle, set wins.
- Pending vector: pend = irq_edge_i ? (epend_q | edge) : irq_q, evaluated per line. mip_o = pend.
- Eligibility: elig[k] = pend[k] & irq_en_i[k] & (prio[k] > irq_thresh_i) & m_ie_i.
  - A line with priority 0 is therefore never eligible.
- Arbitration (combinational over elig):
  - Winner is the line with the highest prio.
  - Ties go to the highest index.
  - any = |elig.
- Latency: irq_i rising in cycle 0 → irq_q in cycle 1 → irq_req_ctrl_o=1 in cycle 2. This holds for both trigger modes.
- FSM, state IDLE:
  - If any: go to REQ; load id/prio from the winner; req=1.
  - Otherwise req=0.
- FSM, state REQ:
  - irq_ack_i=1: go to IDLE; req=0 next cycle. If the acked line is edge-mode, clear its epend bit. A level-mode line re-requests from IDLE if it is still asserted.
  - else if !any: withdraw. Go to IDLE; req=0 next cycle.
  - else if winner prio > held prio: preempt. Reload id/prio and stay in REQ.
  - else if the held line is no longer eligible: reload from the winner.
  - Otherwise id/prio hold.
- irq_ack_i is ignored in IDLE.
- The controller samples id/prio in the cycle it asserts irq_ack_i.
- Configuration changes (enable, prio, thresh, m_ie) take effect on eligibility in the same cycle and on the outputs in the next cycle.
- Reset asserted mid-request: outputs go to 0 asynchronously and all pending edges are lost.

Decomposition:
- cv32e40x_pkg holds:
  - clic_state_e {IDLE, REQ}.
  - A function clic_id_w(NUM_IRQ) returning $clog2.
- One sub-module: cv32e40x_clic_arbiter.
  - Parametrised combinational tree of NUM_IRQ leaves, compare-and-select on {prio, index}.
  - Outputs any, id and prio.
  - Depth is log2(NUM_IRQ).

Test Plan:
1. Level line 5, prio 3, thresh 0, en=1, m_ie=1: irq_i[5] rises at cycle 0 → req=1, id=5, prio=3 at cycle 2. Drop irq_i[5] with no ack → req=0 two cycles later.
2. Edge line 9: a 1-cycle pulse on irq_i[9] → mip_o[9] stays 1 after the pulse and req holds id=9. Ack → mip_o[9]=0 and req=0 next cycle, with no re-request.
3. Priority and tie:
   - Lines 2 (prio 4), 7 (prio 4) and 40 (prio 2) all asserted → id=7.
   - Then raise line 1 at prio 6 while in REQ → preempt, id=1, prio=6, with no req gap.
4. Threshold and enables:
   - thresh=4 with line 3 at prio 4 → no req.
   - Set thresh=3 → req id=3 one cycle later.
   - Clear m_ie → req=0 next cycle.
   - irq_wu_ctrl_o=1 throughout, independent of m_ie.
5. Edge set/ack collision: a new rising edge on line 9 in the same cycle as the ack of id 9 → epend[9] stays 1 and req re-asserts with id=9.
6. Assert rst during REQ with 3 edge pendings → all outputs 0 immediately. After release: no req until a new edge arrives.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// Shared types and helpers for the CLIC-style interrupt controller.
package cv32e40x_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } clic_state_e;

  // Width of a line id; kept at 1 or more so a degenerate configuration still elaborates.
  function automatic int clic_id_w(input int num_irq);
    return (num_irq > 1) ? $clog2(num_irq) : 1;
  endfunction

endpackage

// File: rtl/cv32e40x_clic_arbiter.sv
// Combinational priority tree: picks the eligible line with the highest priority, highest index on ties.
module cv32e40x_clic_arbiter
  import cv32e40x_pkg::*;
#(
  parameter  int NUM_IRQ   = 64,
  parameter  int PRIO_BITS = 3,
  localparam int ID_W      = clic_id_w(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0]           elig_i,
  input  logic [NUM_IRQ*PRIO_BITS-1:0] prio_i,
  output logic                         any_o,
  output logic [ID_W-1:0]              id_o,
  output logic [PRIO_BITS-1:0]         prio_o
);

  localparam int N2 = 1 << ID_W;

  for (genvar l = 0; l <= ID_W; l++) begin : g_lvl
    localparam int W = N2 >> l;
    logic [W-1:0]                vld;
    logic [W-1:0][PRIO_BITS-1:0] pri;
    logic [W-1:0][ID_W-1:0]      idx;

    if (l == 0) begin : g_leaf
      for (genvar n = 0; n < W; n++) begin : g_n
        if (n < NUM_IRQ) begin : g_real
          assign vld[n] = elig_i[n];
          assign pri[n] = prio_i[n*PRIO_BITS +: PRIO_BITS];
        end else begin : g_pad
          assign vld[n] = 1'b0;
          assign pri[n] = '0;
        end
        assign idx[n] = ID_W'(n);
      end
    end else begin : g_node
      for (genvar n = 0; n < W; n++) begin : g_n
        logic pick_r;
        // The right child always holds the higher indices, so >= resolves ties towards them.
        assign pick_r = g_lvl[l-1].vld[2*n+1] &
                        (~g_lvl[l-1].vld[2*n] |
                         (g_lvl[l-1].pri[2*n+1] >= g_lvl[l-1].pri[2*n]));
        assign vld[n] = g_lvl[l-1].vld[2*n] | g_lvl[l-1].vld[2*n+1];
        assign pri[n] = pick_r ? g_lvl[l-1].pri[2*n+1] : g_lvl[l-1].pri[2*n];
        assign idx[n] = pick_r ? g_lvl[l-1].idx[2*n+1] : g_lvl[l-1].idx[2*n];
      end
    end
  end

  assign any_o  = g_lvl[ID_W].vld[0];
  assign id_o   = g_lvl[ID_W].idx[0];
  assign prio_o = g_lvl[ID_W].pri[0];

endmodule

// File: rtl/cv32e40x_clic_int_controller.sv
// Level/edge interrupt controller: synchronises lines, latches edges, arbitrates against a
// threshold and holds one registered request until ack, withdrawal or preemption.
module cv32e40x_clic_int_controller
  import cv32e40x_pkg::*;
#(
  parameter  int                 NUM_IRQ    = 64,
  parameter  int                 PRIO_BITS  = 3,
  parameter  logic [NUM_IRQ-1:0] IRQ_MASK_P = '1,
  localparam int                 ID_W       = clic_id_w(NUM_IRQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IRQ-1:0]           irq_i,
  input  logic [NUM_IRQ-1:0]           irq_en_i,
  input  logic [NUM_IRQ-1:0]           irq_edge_i,
  input  logic [NUM_IRQ*PRIO_BITS-1:0] irq_prio_i,
  input  logic [PRIO_BITS-1:0]         irq_thresh_i,
  input  logic                         m_ie_i,
  input  logic                         irq_ack_i,
  output logic                         irq_req_ctrl_o,
  output logic [ID_W-1:0]              irq_id_ctrl_o,
  output logic [PRIO_BITS-1:0]         irq_prio_ctrl_o,
  output logic                         irq_wu_ctrl_o,
  output logic [NUM_IRQ-1:0]           mip_o
);

  logic [NUM_IRQ-1:0]   irq_q, irq_q2;
  logic [NUM_IRQ-1:0]   epend_q, epend_d, epend_clr;
  logic [NUM_IRQ-1:0]   edge_det, pend, elig;
  clic_state_e          state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [PRIO_BITS-1:0] prio_q, prio_d;
  logic                 win_any;
  logic [ID_W-1:0]      win_id;
  logic [PRIO_BITS-1:0] win_prio;

  // Wake-up bypasses the synchroniser so a clock-gated core can be woken.
  assign irq_wu_ctrl_o = |(irq_i & irq_en_i & IRQ_MASK_P);

  assign edge_det = irq_q & ~irq_q2;
  assign pend     = (irq_edge_i & (epend_q | edge_det)) | (~irq_edge_i & irq_q);
  assign mip_o    = pend;
  // A fresh edge ORed in after the clear makes set win over a same-cycle ack.
  assign epend_d  = (epend_q & ~epend_clr) | edge_det;

  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      elig[k] = pend[k] & irq_en_i[k] & m_ie_i &
                (irq_prio_i[k*PRIO_BITS +: PRIO_BITS] > irq_thresh_i);
    end
  end

  cv32e40x_clic_arbiter #(
    .NUM_IRQ   (NUM_IRQ),
    .PRIO_BITS (PRIO_BITS)
  ) u_arbiter (
    .elig_i (elig),
    .prio_i (irq_prio_i),
    .any_o  (win_any),
    .id_o   (win_id),
    .prio_o (win_prio)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    id_d      = id_q;
    prio_d    = prio_q;
    epend_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = REQ;
          id_d    = win_id;
          prio_d  = win_prio;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_d   = IDLE;
          epend_clr = NUM_IRQ'(1) << id_q;
        end else if (!win_any) begin
          state_d = IDLE;
        end else if ((win_prio > prio_q) || !elig[id_q]) begin
          id_d   = win_id;
          prio_d = win_prio;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q   <= '0;
      irq_q2  <= '0;
      epend_q <= '0;
      state_q <= IDLE;
      id_q    <= '0;
      prio_q  <= '0;
    end else begin
      irq_q   <= irq_i & IRQ_MASK_P;
      irq_q2  <= irq_q;
      epend_q <= epend_d;
      state_q <= state_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
    end
  end

  assign irq_req_ctrl_o  = (state_q == REQ);
  assign irq_id_ctrl_o   = id_q;
  assign irq_prio_ctrl_o = prio_q;

endmodule

// File: tb/tb_cv32e40x_clic_int_controller.sv
// Self-checking bench: directed scenarios plus random traffic, compared every cycle with a line-level model.
module tb_cv32e40x_clic_int_controller;

  localparam int NUM = 64;
  localparam int PB  = 3;
  localparam int IDW = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM-1:0]    irq, en, edg;
  logic [NUM*PB-1:0] prio_flat;
  logic [PB-1:0]     thresh;
  logic              m_ie, ack;
  logic              req_o, wu_o;
  logic [IDW-1:0]    id_o;
  logic [PB-1:0]     prio_o;
  logic [NUM-1:0]    mip_o;

  int prio_a[NUM];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: the last two samples of each line, latched edges, and the held request.
  bit [NUM-1:0] m_q, m_q2, m_ep, m_pend, m_elig, m_edge;
  bit           m_req, m_any;
  int           m_id, m_prio, m_bid, m_bp;

  always #5 clk = ~clk;

  always_comb begin
    prio_flat = '0;
    for (int k = 0; k < NUM; k++) prio_flat[k*PB +: PB] = PB'(prio_a[k]);
  end

  cv32e40x_clic_int_controller #(
    .NUM_IRQ   (NUM),
    .PRIO_BITS (PB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .irq_i           (irq),
    .irq_en_i        (en),
    .irq_edge_i      (edg),
    .irq_prio_i      (prio_flat),
    .irq_thresh_i    (thresh),
    .m_ie_i          (m_ie),
    .irq_ack_i       (ack),
    .irq_req_ctrl_o  (req_o),
    .irq_id_ctrl_o   (id_o),
    .irq_prio_ctrl_o (prio_o),
    .irq_wu_ctrl_o   (wu_o),
    .mip_o           (mip_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_q = '0; m_q2 = '0; m_ep = '0;
    m_req = 1'b0; m_id = 0; m_prio = 0;
  endtask

  // Derive pending/eligible lines and the winner from the model's view of the lines.
  task automatic model_eval();
    m_any = 1'b0; m_bid = 0; m_bp = -1;
    for (int k = 0; k < NUM; k++) begin
      m_edge[k] = m_q[k] && !m_q2[k];
      m_pend[k] = edg[k] ? (m_ep[k] || m_edge[k]) : m_q[k];
      m_elig[k] = m_pend[k] && en[k] && m_ie && (prio_a[k] > int'(thresh));
      if (m_elig[k] && prio_a[k] >= m_bp) begin
        m_any = 1'b1; m_bid = k; m_bp = prio_a[k];
      end
    end
  endtask

  task automatic model_step();
    int clr;
    clr = -1;
    model_eval();
    if (!m_req) begin
      if (m_any) begin m_req = 1'b1; m_id = m_bid; m_prio = m_bp; end
    end else if (ack) begin
      m_req = 1'b0; clr = m_id;
    end else if (!m_any) begin
      m_req = 1'b0;
    end else if (m_bp > m_prio || !m_elig[m_id]) begin
      m_id = m_bid; m_prio = m_bp;
    end
    if (clr >= 0) m_ep[clr] = 1'b0;
    m_ep = m_ep | m_edge;
    m_q2 = m_q;
    m_q  = irq;
  endtask

  // One clock: compare everything mid-cycle, advance the model, then return just after the edge.
  task automatic tick();
    @(negedge clk);
    model_eval();
    check("req",  64'(req_o),  64'(m_req));
    check("id",   64'(id_o),   64'(m_id));
    check("prio", 64'(prio_o), 64'(m_prio));
    check("mip",  64'(mip_o),  64'(m_pend));
    check("wu",   64'(wu_o),   64'(|(irq & en)));
    if (!rst) model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; irq = '0; en = '1; edg = '0; thresh = '0; m_ie = 1'b1; ack = 1'b0;
    for (int k = 0; k < NUM; k++) prio_a[k] = 0;
    model_reset();
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_req", 64'(req_o), 64'd0);
    check("rst_id",  64'(id_o),  64'd0);
    check("rst_mip", 64'(mip_o), 64'd0);
    rst = 1'b0;

    // Level line: two-cycle latency, withdrawal without ack.
    prio_a[5] = 3; irq[5] = 1'b1;
    tick(); tick();
    check("t1_req", 64'(req_o), 64'd1);
    check("t1_id", 64'(id_o), 64'd5);
    check("t1_prio", 64'(prio_o), 64'd3);
    irq[5] = 1'b0;
    tick(); tick();
    check("t1_withdraw", 64'(req_o), 64'd0);

    // Edge line: pulse latched, ack clears it without re-request.
    edg[9] = 1'b1; prio_a[9] = 2; irq[9] = 1'b1;
    tick(); irq[9] = 1'b0; tick();
    check("t2_req", 64'(req_o), 64'd1);
    check("t2_id", 64'(id_o), 64'd9);
    tick(); tick();
    check("t2_mip_held", 64'(mip_o[9]), 64'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("t2_ack_req", 64'(req_o), 64'd0);
    check("t2_ack_mip", 64'(mip_o[9]), 64'd0);
    tick();
    check("t2_no_rereq", 64'(req_o), 64'd0);

    // Tie goes to the highest index, then a higher priority preempts without a gap.
    prio_a[2] = 4; prio_a[7] = 4; prio_a[40] = 2;
    irq[2] = 1'b1; irq[7] = 1'b1; irq[40] = 1'b1;
    tick(); tick();
    check("t3_tie_id", 64'(id_o), 64'd7);
    check("t3_tie_prio", 64'(prio_o), 64'd4);
    prio_a[1] = 6; irq[1] = 1'b1;
    tick();
    check("t3_nogap", 64'(req_o), 64'd1);
    tick();
    check("t3_pre_req", 64'(req_o), 64'd1);
    check("t3_pre_id", 64'(id_o), 64'd1);
    check("t3_pre_prio", 64'(prio_o), 64'd6);
    irq = '0;
    repeat (3) tick();

    // Threshold is strict, global enable gates requests but not wake-up.
    thresh = 3'd4; prio_a[3] = 4; irq[3] = 1'b1;
    repeat (3) tick();
    check("t4_thresh_block", 64'(req_o), 64'd0);
    check("t4_wu", 64'(wu_o), 64'd1);
    thresh = 3'd3;
    tick();
    check("t4_thresh_req", 64'(req_o), 64'd1);
    check("t4_thresh_id", 64'(id_o), 64'd3);
    m_ie = 1'b0;
    tick();
    check("t4_mie_off", 64'(req_o), 64'd0);
    check("t4_wu_mie_off", 64'(wu_o), 64'd1);
    m_ie = 1'b1; irq[3] = 1'b0; thresh = '0;
    repeat (4) tick();

    // New edge on line 9 in the same cycle as its ack keeps it pending.
    irq[9] = 1'b1; tick(); irq[9] = 1'b0; tick();
    check("t5_req", 64'(req_o), 64'd1);
    check("t5_id", 64'(id_o), 64'd9);
    irq[9] = 1'b1; tick();
    irq[9] = 1'b0; ack = 1'b1; tick(); ack = 1'b0;
    check("t5_ack_req", 64'(req_o), 64'd0);
    check("t5_set_wins", 64'(mip_o[9]), 64'd1);
    tick();
    check("t5_rereq", 64'(req_o), 64'd1);
    check("t5_rereq_id", 64'(id_o), 64'd9);
    ack = 1'b1; tick(); ack = 1'b0; tick();
    check("t5_done", 64'(req_o), 64'd0);

    // Asynchronous reset mid-request drops every latched edge.
    edg[12:10] = 3'b111; prio_a[10] = 5; prio_a[11] = 6; prio_a[12] = 7;
    irq[12:10] = 3'b111; tick(); irq = '0; tick();
    check("t6_req", 64'(req_o), 64'd1);
    check("t6_id", 64'(id_o), 64'd12);
    #2 rst = 1'b1; #1;
    check("t6_rst_req", 64'(req_o), 64'd0);
    check("t6_rst_id", 64'(id_o), 64'd0);
    check("t6_rst_prio", 64'(prio_o), 64'd0);
    check("t6_rst_mip", 64'(mip_o), 64'd0);
    model_reset();
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t6_no_req", 64'(req_o), 64'd0);
    irq[10] = 1'b1; tick(); irq[10] = 1'b0; tick();
    check("t6_new_req", 64'(req_o), 64'd1);
    check("t6_new_id", 64'(id_o), 64'd10);
    ack = 1'b1; tick(); ack = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        for (int k = 0; k < NUM; k++) prio_a[k] = int'($urandom_range(0, 7));
        en  = {$urandom, $urandom} | {$urandom, $urandom};
        edg = {$urandom, $urandom};
      end
      irq = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom % 40 == 0) thresh = PB'($urandom_range(0, 4));
      m_ie = ($urandom % 30) != 0;
      ack  = ($urandom % 3) == 0;
      tick();
    end
    ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
